sprite_bounce_drive: RTL and testbench

// Pixel-data source for the VGA picture path: places an IMG_W x IMG_H image from an external

---
 rtl/sprite_bounce_drive.sv | 130 +++++++++++++
 tb/tb_sprite_bounce_drive.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/sprite_bounce_drive.sv
// Sprite pixel source: places a ROM image on the visible screen, bounces it once per frame,
// applies an optional colour key and aligns the window flag with the ROM read latency.
module sprite_bounce_drive #(
  parameter int                 H_ACTIVE  = 640,
  parameter int                 V_ACTIVE  = 480,
  parameter int                 IMG_W     = 48,
  parameter int                 IMG_H     = 48,
  parameter int                 DATA_W    = 16,
  parameter int                 ADDR_W    = 14,
  parameter int                 ROM_LAT   = 1,
  parameter int                 STEP      = 1,
  parameter logic [DATA_W-1:0]  BG_COLOR  = '0,
  parameter bit                 KEY_EN    = 1'b0,
  parameter logic [DATA_W-1:0]  KEY_COLOR = DATA_W'(16'hF81F)
) (
  input  logic              vga_clk,
  input  logic              rst_n,
  input  logic [11:0]       addr_h,
  input  logic [11:0]       addr_v,
  input  logic              move_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] rgb_data,
  output logic              frame_tick
);

  localparam logic [12:0] X_MAX  = 13'(H_ACTIVE - IMG_W);
  localparam logic [12:0] Y_MAX  = 13'(V_ACTIVE - IMG_H);
  localparam logic [12:0] X_INIT = 13'((H_ACTIVE - IMG_W) / 2);
  localparam logic [12:0] Y_INIT = 13'((V_ACTIVE - IMG_H) / 2);
  localparam logic [12:0] STEP_W = 13'(STEP);

  logic [12:0]       x_pos_reg, x_pos_next;
  logic [12:0]       y_pos_reg, y_pos_next;
  logic              dir_x_reg, dir_x_next;
  logic              dir_y_reg, dir_y_next;
  logic [12:0]       ah, av, x_last, y_last, dh, dv;
  logic              in_win;
  logic              tick;
  logic [ADDR_W-1:0] addr_calc;
  logic              win_aligned;

  // One axis of motion; returns {dir, pos} with dir 1 meaning increasing.
  function automatic logic [13:0] axis_next(input logic [12:0] pos, input logic dir,
                                            input logic [12:0] lim);
    logic [13:0] r;
    if (dir) begin
      if (pos + STEP_W >= lim) r = {1'b0, lim};
      else                     r = {1'b1, pos + STEP_W};
    end else begin
      if (pos <= STEP_W) r = {1'b1, 13'd0};
      else               r = {1'b0, pos - STEP_W};
    end
    return r;
  endfunction

  always_comb begin
    ah        = {1'b0, addr_h};
    av        = {1'b0, addr_v};
    x_last    = x_pos_reg + 13'(IMG_W - 1);
    y_last    = y_pos_reg + 13'(IMG_H - 1);
    in_win    = (ah >= x_pos_reg) && (ah <= x_last) && (av >= y_pos_reg) && (av <= y_last);
    dh        = ah - x_pos_reg;
    dv        = av - y_pos_reg;
    // Address derived from the beam position so any glitch is corrected on the next pixel.
    addr_calc = ADDR_W'(dv) * ADDR_W'(IMG_W) + ADDR_W'(dh);
    tick      = (addr_v == 12'(V_ACTIVE)) && (addr_h == 12'd0);
  end

  always_comb begin
    x_pos_next = x_pos_reg;
    y_pos_next = y_pos_reg;
    dir_x_next = dir_x_reg;
    dir_y_next = dir_y_reg;
    if (tick && move_en) begin
      {dir_x_next, x_pos_next} = axis_next(x_pos_reg, dir_x_reg, X_MAX);
      {dir_y_next, y_pos_next} = axis_next(y_pos_reg, dir_y_reg, Y_MAX);
    end
  end

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      x_pos_reg  <= X_INIT;
      y_pos_reg  <= Y_INIT;
      dir_x_reg  <= 1'b1;
      dir_y_reg  <= 1'b1;
      rom_addr   <= '0;
      frame_tick <= 1'b0;
    end else begin
      x_pos_reg  <= x_pos_next;
      y_pos_reg  <= y_pos_next;
      dir_x_reg  <= dir_x_next;
      dir_y_reg  <= dir_y_next;
      frame_tick <= tick;
      if (in_win) rom_addr <= addr_calc;
    end
  end

  // Window flag delay line: stage 0 lines up with rom_addr, stage ROM_LAT with rom_data.
  genvar gi;
  generate
    for (gi = 0; gi <= ROM_LAT; gi++) begin : win_stage
      logic stage_reg;
      if (gi == 0) begin : g_first
        always_ff @(posedge vga_clk or negedge rst_n) begin
          if (!rst_n) stage_reg <= 1'b0;
          else        stage_reg <= in_win;
        end
      end else begin : g_next
        always_ff @(posedge vga_clk or negedge rst_n) begin
          if (!rst_n) stage_reg <= 1'b0;
          else        stage_reg <= win_stage[gi-1].stage_reg;
        end
      end
    end
  endgenerate

  assign win_aligned = win_stage[ROM_LAT].stage_reg;

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_data <= BG_COLOR;
    end else if (!win_aligned || (KEY_EN && (rom_data == KEY_COLOR))) begin
      rgb_data <= BG_COLOR;
    end else begin
      rgb_data <= rom_data;
    end
  end

endmodule

// File: tb/tb_sprite_bounce_drive.sv
// Bench for sprite_bounce_drive: two instances (default, and keyed/STEP=4) fed by one beam,
// with a latency-3 scoreboard on rgb_data and per-step checks of rom_addr and frame_tick.
module tb_sprite_bounce_drive;
  localparam int HA = 640, VA = 480, IW = 48, IH = 48;
  localparam logic [15:0] BG_A = 16'h0000;
  localparam logic [15:0] BG_B = 16'h07E0;

  logic        vga_clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [11:0] addr_h = '0, addr_v = '0;
  logic        move_en_a = 1'b0, move_en_b = 1'b0;
  logic [13:0] rom_addr_a, rom_addr_b;
  logic [15:0] rom_data_a, rom_data_b, rgb_a, rgb_b;
  logic        tick_a, tick_b;

  int tests = 0, fails = 0, pulses = 0;
  int xa, ya, xb, yb, la, lb;
  bit dxa, dya, dxb, dyb;
  logic [15:0] qa[$], qb[$];

  always #5 vga_clk = ~vga_clk;

  sprite_bounce_drive #(.BG_COLOR(BG_A)) dut_a (
    .vga_clk(vga_clk), .rst_n(rst_n), .addr_h(addr_h), .addr_v(addr_v), .move_en(move_en_a),
    .rom_addr(rom_addr_a), .rom_data(rom_data_a), .rgb_data(rgb_a), .frame_tick(tick_a));

  sprite_bounce_drive #(.STEP(4), .KEY_EN(1'b1), .BG_COLOR(BG_B)) dut_b (
    .vga_clk(vga_clk), .rst_n(rst_n), .addr_h(addr_h), .addr_v(addr_v), .move_en(move_en_b),
    .rom_addr(rom_addr_b), .rom_data(rom_data_b), .rgb_data(rgb_b), .frame_tick(tick_b));

  function automatic logic [15:0] rom_val(input int a);
    return (a == 5) ? 16'hF81F : 16'(a);
  endfunction

  always @(posedge vga_clk) begin
    rom_data_a <= rom_val(int'(rom_addr_a));
    rom_data_b <= rom_val(int'(rom_addr_b));
  end

  function automatic bit in_win(input int h, v, x, y);
    return (h >= x) && (h <= x + IW - 1) && (v >= y) && (v <= y + IH - 1);
  endfunction

  function automatic logic [15:0] exp_pix(input int h, v, x, y, input bit key,
                                          input logic [15:0] bg);
    logic [15:0] d;
    if (!in_win(h, v, x, y)) return bg;
    d = rom_val((v - y) * IW + (h - x));
    if (key && d == 16'hF81F) return bg;
    return d;
  endfunction

  function automatic void adv(inout int p, inout bit d, input int lim, input int s);
    if (d) begin
      if (p + s >= lim) begin p = lim; d = 1'b0; end
      else p = p + s;
    end else begin
      if (p <= s) begin p = 0; d = 1'b1; end
      else p = p - s;
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    xa = (HA - IW) / 2; ya = (VA - IH) / 2; xb = xa; yb = ya;
    dxa = 1; dya = 1; dxb = 1; dyb = 1;
    la = 0; lb = 0;
    qa.delete(); qb.delete();
  endtask

  task automatic step(input int h, input int v);
    bit is_tick;
    addr_h = 12'(h);
    addr_v = 12'(v);
    qa.push_back(exp_pix(h, v, xa, ya, 1'b0, BG_A));
    qb.push_back(exp_pix(h, v, xb, yb, 1'b1, BG_B));
    if (in_win(h, v, xa, ya)) la = (v - ya) * IW + (h - xa);
    if (in_win(h, v, xb, yb)) lb = (v - yb) * IW + (h - xb);
    is_tick = (v == VA) && (h == 0);
    if (is_tick && move_en_a) begin adv(xa, dxa, HA - IW, 1); adv(ya, dya, VA - IH, 1); end
    if (is_tick && move_en_b) begin adv(xb, dxb, HA - IW, 4); adv(yb, dyb, VA - IH, 4); end
    @(posedge vga_clk);
    #1;
    check("rom_addr_a", 32'(rom_addr_a), 32'(la));
    check("rom_addr_b", 32'(rom_addr_b), 32'(lb));
    check("frame_tick_a", 32'(tick_a), 32'(is_tick));
    check("frame_tick_b", 32'(tick_b), 32'(is_tick));
    if (tick_a) pulses++;
    if (qa.size() == 3) begin
      check("rgb_a", 32'(rgb_a), 32'(qa.pop_front()));
      check("rgb_b", 32'(rgb_b), 32'(qb.pop_front()));
    end
  endtask

  task automatic flush();
    repeat (3) step(700, 500);
  endtask

  task automatic scan(input int v0, v1, h0, h1, input int stop_v, stop_h);
    for (int v = v0; v <= v1; v++)
      for (int h = h0; h <= h1; h++) begin
        if (v == stop_v && h == stop_h) return;
        step(h, v);
      end
    flush();
  endtask

  task automatic check_pos();
    check("x_pos_a", 32'(dut_a.x_pos_reg), 32'(xa));
    check("y_pos_a", 32'(dut_a.y_pos_reg), 32'(ya));
    check("x_pos_b", 32'(dut_b.x_pos_reg), 32'(xb));
    check("y_pos_b", 32'(dut_b.y_pos_reg), 32'(yb));
    check("dir_x_b", 32'(dut_b.dir_x_reg), 32'(dxb));
    check("dir_y_b", 32'(dut_b.dir_y_reg), 32'(dyb));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_rgb_a", 32'(rgb_a), 32'(BG_A));
    check("rst_rgb_b", 32'(rgb_b), 32'(BG_B));
    check("rst_rom_addr_a", 32'(rom_addr_a), 32'd0);
    check("rst_frame_tick", 32'(tick_a), 32'd0);
    model_reset();
    check_pos();
    repeat (2) @(posedge vga_clk);
    #1;
    check("rst_hold_rgb_a", 32'(rgb_a), 32'(BG_A));
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    #2;
    do_reset();
    $display("[TB] reset checked");

    scan(214, 265, 294, 345, -1, -1);
    step(0, 0); step(639, 479); step(296, 216); step(343, 263); flush();
    $display("[TB] centred frame scan done, tests=%0d", tests);

    pulses = 0;
    for (int f = 0; f < 3; f++) begin
      step(0, VA); step(1, VA); step(10, 10);
      check_pos();
    end
    flush();
    check("tick_count", 32'(pulses), 32'd3);
    $display("[TB] hold frames done, pulses=%0d", pulses);

    scan(214, 265, 294, 345, 240, 320);
    do_reset();
    scan(214, 265, 294, 345, -1, -1);
    $display("[TB] mid-image reset and recovery done, tests=%0d", tests);

    move_en_a = 1'b1;
    move_en_b = 1'b1;
    for (int i = 0; i < 250; i++) begin
      step(0, VA);
      step(5, VA);
      check_pos();
      if (i == 73)  begin check("clamp_x", 32'(dut_b.x_pos_reg), 32'd592);
                          check("rev_x",   32'(dut_b.dir_x_reg), 32'd0); end
      if (i == 74)  check("back_x", 32'(dut_b.x_pos_reg), 32'd588);
      if (i == 53)  check("clamp_y_hi", 32'(dut_b.y_pos_reg), 32'd432);
      if (i == 161) begin check("clamp_y_lo", 32'(dut_b.y_pos_reg), 32'd0);
                          check("rev_y",      32'(dut_b.dir_y_reg), 32'd1); end
    end
    flush();
    $display("[TB] motion done, b at (%0d,%0d)", xb, yb);

    move_en_a = 1'b0;
    move_en_b = 1'b0;
    scan((yb > 0) ? yb - 1 : 0, yb + 2, (xb > 0) ? xb - 1 : 0, xb + 2, -1, -1);
    scan((ya > 0) ? ya - 1 : 0, ya + 2, (xa > 0) ? xa - 1 : 0, xa + 2, -1, -1);
    $display("[TB] moved-window corners done");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
